hazard_ctrl: RTL and testbench

Parametrised interlock and forwarding controller for the multi-stage integer pipeline. It tracks every in-flight destination register from execute through writeback and selects an operand forwarding source for each decode-stage source register. It detects load-use hazards and raises a stall that inserts a bubble. It kills wrong-path instructions when a branch resolves taken. Decode, exec and mem stages take their operand-mux selects, hold enables and kill signals from this block.

---
 rtl/pipeline_pkg.sv | 18 +
 rtl/hazard_ctrl_if.sv | 38 +++
 rtl/hz_match.sv | 37 +++
 rtl/hazard_ctrl.sv | 102 ++++++++++
 tb/tb_hazard_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: tracked-entry field widths, forwarding source
// encoding and the stage indices used by exec/mem_unit operand muxes.
package pipeline_pkg;

    localparam int unsigned ENT_VALID_W    = 1;
    localparam int unsigned ENT_RD_W       = 5;
    localparam int unsigned ENT_REGWRITE_W = 1;
    localparam int unsigned ENT_LOAD_W     = 1;

    localparam int unsigned FWD_RF = 0;

    typedef enum logic [1:0] {
        EX  = 2'd1,
        MEM = 2'd2,
        WB  = 2'd3
    } stage_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/branch inputs and interlock/forwarding outputs of the hazard controller.
interface hazard_ctrl_if
    import pipeline_pkg::*;
#(
    parameter int REG_AW = int'(ENT_RD_W),
    parameter int DEPTH  = 3,
    parameter int FW     = $clog2(DEPTH + 1)
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_mem2reg;
    logic              br_taken;

    logic              stall;
    logic              flush;
    logic [FW-1:0]     fwd_a;
    logic [FW-1:0]     fwd_b;
    logic [15:0]       stall_count;
    logic [15:0]       flush_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_regwrite, id_mem2reg, br_taken,
        input  stall, flush, fwd_a, fwd_b, stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_regwrite, id_mem2reg, br_taken,
        output stall, flush, fwd_a, fwd_b, stall_count, flush_count
    );

endinterface

// File: rtl/hz_match.sv
// Priority search of one decode source register over the tracked stages;
// returns the youngest matching stage (1-based, 0 = none) and whether it is a load.
module hz_match
    import pipeline_pkg::*;
#(
    parameter int REG_AW = int'(ENT_RD_W),
    parameter int DEPTH  = 3,
    parameter int FW     = $clog2(DEPTH + 1)
) (
    input  logic                         use_i,
    input  logic [REG_AW-1:0]            rs_i,
    input  logic [DEPTH-1:0]             valid_i,
    input  logic [DEPTH-1:0][REG_AW-1:0] rd_i,
    input  logic [DEPTH-1:0]             regwrite_i,
    input  logic [DEPTH-1:0]             load_i,
    output logic [FW-1:0]                sel_o,
    output logic                         is_load_hit_o
);

    logic hit;

    // Index 0 is stage 1 (youngest); the first hit in ascending order wins.
    always_comb begin
        sel_o         = '0;
        is_load_hit_o = 1'b0;
        hit           = 1'b0;
        for (int unsigned k = 0; k < unsigned'(DEPTH); k++) begin
            if (!hit && use_i && (rs_i != '0) && valid_i[k] && regwrite_i[k]
                && (rd_i[k] == rs_i)) begin
                hit           = 1'b1;
                sel_o         = FW'(k + 1);
                is_load_hit_o = load_i[k];
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Interlock and forwarding controller: tracks in-flight destinations from EX to WB,
// selects operand forwarding sources, stalls on load-use and flushes on taken branch.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_AW     = int'(ENT_RD_W),
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int BR_STAGE   = 2,
    parameter int FW         = $clog2(DEPTH + 1)
) (
    input  logic         clock,
    input  logic         reset,
    hazard_ctrl_if.slave bus
);

    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0][REG_AW-1:0] rd_q, rd_d;
    logic [DEPTH-1:0]             regwrite_q, regwrite_d;
    logic [DEPTH-1:0]             load_q, load_d;
    logic [15:0]                  stall_cnt_q, stall_cnt_d;
    logic [15:0]                  flush_cnt_q, flush_cnt_d;

    logic [FW-1:0] sel_a, sel_b;
    logic          load_hit_a, load_hit_b;
    logic          load_use;
    logic          stall, flush;

    hz_match #(.REG_AW(REG_AW), .DEPTH(DEPTH), .FW(FW)) u_match_rs1 (
        .use_i        (bus.id_use_rs1),
        .rs_i         (bus.id_rs1),
        .valid_i      (valid_q),
        .rd_i         (rd_q),
        .regwrite_i   (regwrite_q),
        .load_i       (load_q),
        .sel_o        (sel_a),
        .is_load_hit_o(load_hit_a)
    );

    hz_match #(.REG_AW(REG_AW), .DEPTH(DEPTH), .FW(FW)) u_match_rs2 (
        .use_i        (bus.id_use_rs2),
        .rs_i         (bus.id_rs2),
        .valid_i      (valid_q),
        .rd_i         (rd_q),
        .regwrite_i   (regwrite_q),
        .load_i       (load_q),
        .sel_o        (sel_b),
        .is_load_hit_o(load_hit_b)
    );

    assign load_use = (load_hit_a && (sel_a < FW'(LOAD_STAGE)))
                   || (load_hit_b && (sel_b < FW'(LOAD_STAGE)));
    assign flush    = bus.br_taken;
    assign stall    = bus.id_valid && load_use && !flush;

    assign bus.stall       = stall;
    assign bus.flush       = flush;
    assign bus.fwd_a       = stall ? FW'(FWD_RF) : sel_a;
    assign bus.fwd_b       = stall ? FW'(FWD_RF) : sel_b;
    assign bus.stall_count = stall_cnt_q;
    assign bus.flush_count = flush_cnt_q;

    // Entries leaving stages 1..BR_STAGE-1 on a flush are wrong-path and arrive as bubbles.
    always_comb begin
        valid_d       = '0;
        rd_d          = '0;
        regwrite_d    = '0;
        load_d        = '0;
        valid_d[0]    = bus.id_valid && !stall && !flush;
        rd_d[0]       = bus.id_rd;
        regwrite_d[0] = bus.id_regwrite;
        load_d[0]     = bus.id_mem2reg;
        for (int unsigned k = 1; k < unsigned'(DEPTH); k++) begin
            valid_d[k]    = valid_q[k-1] && !(flush && (k < unsigned'(BR_STAGE)));
            rd_d[k]       = rd_q[k-1];
            regwrite_d[k] = regwrite_q[k-1];
            load_d[k]     = load_q[k-1];
        end

        stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 16'd1 : stall_cnt_q;
        flush_cnt_d = (flush && (flush_cnt_q != '1)) ? flush_cnt_q + 16'd1 : flush_cnt_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q     <= '0;
            rd_q        <= '0;
            regwrite_q  <= '0;
            load_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            rd_q        <= rd_d;
            regwrite_q  <= regwrite_d;
            load_q      <= load_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline sequences against an in-bench stage model,
// plus a deep-pipeline instance that drives the stall counter into saturation.
module tb_hazard_ctrl;

    logic clock = 1'b0;
    logic rst_n = 1'b0;

    always #5 clock = ~clock;

    hazard_ctrl_if #(.REG_AW(5), .DEPTH(3))  bus  ();
    hazard_ctrl_if #(.REG_AW(5), .DEPTH(16)) bus2 ();

    hazard_ctrl #(.REG_AW(5), .DEPTH(3), .LOAD_STAGE(2), .BR_STAGE(2)) dut (
        .clock(clock),
        .reset(rst_n),
        .bus  (bus)
    );

    hazard_ctrl #(.REG_AW(5), .DEPTH(16), .LOAD_STAGE(16), .BR_STAGE(2)) dut_deep (
        .clock(clock),
        .reset(rst_n),
        .bus  (bus2)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: what each of stages 1..3 currently holds.
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } ent_t;

    ent_t st [1:3];
    int   m_sc = 0;
    int   m_fc = 0;
    bit   model_ok = 1'b0;

    function automatic int youngest(input logic use_r, input logic [4:0] rs, output logic ld);
        ld = 1'b0;
        if (!use_r || rs == 5'd0) return 0;
        for (int k = 1; k <= 3; k++) begin
            if (st[k].v && st[k].wr && st[k].rd == rs) begin
                ld = st[k].ld;
                return k;
            end
        end
        return 0;
    endfunction

    function automatic void model_out(output logic s, output logic f, output int fa, output int fb);
        logic la, lb;
        int   ka, kb;
        ka = youngest(bus.id_use_rs1, bus.id_rs1, la);
        kb = youngest(bus.id_use_rs2, bus.id_rs2, lb);
        f  = bus.br_taken;
        s  = bus.id_valid && ((la && ka < 2) || (lb && kb < 2)) && !bus.br_taken;
        fa = s ? 0 : ka;
        fb = s ? 0 : kb;
    endfunction

    always @(posedge clock) begin
        logic s, f;
        int   fa, fb;
        ent_t nxt;
        if (!rst_n) begin
            for (int k = 1; k <= 3; k++) st[k] = '0;
            m_sc     = 0;
            m_fc     = 0;
            model_ok = 1'b1;
        end else begin
            model_out(s, f, fa, fb);
            nxt.v  = bus.id_valid && !s && !f;
            nxt.rd = bus.id_rd;
            nxt.wr = bus.id_regwrite;
            nxt.ld = bus.id_mem2reg;
            st[3]  = st[2];
            st[2]  = f ? ent_t'(0) : st[1];
            st[1]  = nxt;
            if (s && m_sc < 65535) m_sc++;
            if (f && m_fc < 65535) m_fc++;
        end
    end

    always @(negedge clock) begin
        logic s, f;
        int   fa, fb;
        if (model_ok) begin
            model_out(s, f, fa, fb);
            check("m_stall", 32'(bus.stall), 32'(s));
            check("m_flush", 32'(bus.flush), 32'(f));
            check("m_fwd_a", 32'(bus.fwd_a), fa);
            check("m_fwd_b", 32'(bus.fwd_b), fb);
            check("m_stall_count", 32'(bus.stall_count), m_sc);
            check("m_flush_count", 32'(bus.flush_count), m_fc);
        end
    end

    task automatic apply(input logic rstn, input logic v,
                         input logic u1, input logic [4:0] rs1,
                         input logic u2, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic wr, input logic ld,
                         input logic br);
        @(posedge clock);
        #1;
        rst_n           = rstn;
        bus.id_valid    = v;
        bus.id_use_rs1  = u1;
        bus.id_rs1      = rs1;
        bus.id_use_rs2  = u2;
        bus.id_rs2      = rs2;
        bus.id_rd       = rd;
        bus.id_regwrite = wr;
        bus.id_mem2reg  = ld;
        bus.br_taken    = br;
        @(negedge clock);
    endtask

    task automatic apply2(input logic v, input logic u1, input logic [4:0] rs1,
                          input logic [4:0] rd, input logic wr, input logic ld);
        @(posedge clock);
        #1;
        bus2.id_valid    = v;
        bus2.id_use_rs1  = u1;
        bus2.id_rs1      = rs1;
        bus2.id_rd       = rd;
        bus2.id_regwrite = wr;
        bus2.id_mem2reg  = ld;
        @(negedge clock);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

    initial begin
        bus.id_valid = 0; bus.id_use_rs1 = 0; bus.id_rs1 = 0; bus.id_use_rs2 = 0;
        bus.id_rs2 = 0; bus.id_rd = 0; bus.id_regwrite = 0; bus.id_mem2reg = 0;
        bus.br_taken = 0;
        bus2.id_valid = 0; bus2.id_use_rs1 = 0; bus2.id_rs1 = 0; bus2.id_use_rs2 = 0;
        bus2.id_rs2 = 0; bus2.id_rd = 0; bus2.id_regwrite = 0; bus2.id_mem2reg = 0;
        bus2.br_taken = 0;

        // Reset held two cycles with a writer of r3 in decode
        apply(0, 1, 0, 0, 0, 0, 3, 1, 0, 0);
        apply(0, 1, 0, 0, 0, 0, 3, 1, 0, 0);
        check("rst_stall_held", 32'(bus.stall), 0);
        apply(1, 1, 1, 3, 1, 3, 0, 0, 0, 0);
        check("rst_stall", 32'(bus.stall), 0);
        check("rst_fwd_a", 32'(bus.fwd_a), 0);
        check("rst_fwd_b", 32'(bus.fwd_b), 0);
        check("rst_stall_count", 32'(bus.stall_count), 0);
        check("rst_flush_count", 32'(bus.flush_count), 0);

        // add r3, then readers of r3 walk through stages 1..3
        apply(1, 1, 0, 0, 0, 0, 3, 1, 0, 0);
        apply(1, 1, 1, 3, 0, 0, 0, 0, 0, 0);
        check("fw_chain_1", 32'(bus.fwd_a), 1);
        check("fw_chain_1_stall", 32'(bus.stall), 0);
        apply(1, 1, 1, 3, 0, 0, 0, 0, 0, 0);
        check("fw_chain_2", 32'(bus.fwd_a), 2);
        apply(1, 1, 1, 3, 0, 0, 0, 0, 0, 0);
        check("fw_chain_3", 32'(bus.fwd_a), 3);
        apply(1, 1, 1, 3, 0, 0, 0, 0, 0, 0);
        check("fw_chain_0", 32'(bus.fwd_a), 0);
        check("fw_chain_0_stall", 32'(bus.stall), 0);

        // lw r5; add r6,r5,r5 -> one stall cycle, then forward from stage 2
        apply(1, 1, 0, 0, 0, 0, 5, 1, 1, 0);
        apply(1, 1, 1, 5, 1, 5, 6, 1, 0, 0);
        check("lu_stall", 32'(bus.stall), 1);
        check("lu_fwd_a_zero", 32'(bus.fwd_a), 0);
        check("lu_fwd_b_zero", 32'(bus.fwd_b), 0);
        apply(1, 1, 1, 5, 1, 5, 6, 1, 0, 0);
        check("lu_release", 32'(bus.stall), 0);
        check("lu_fwd_a", 32'(bus.fwd_a), 2);
        check("lu_fwd_b", 32'(bus.fwd_b), 2);
        check("lu_stall_count", 32'(bus.stall_count), 1);
        apply(1, 1, 1, 6, 0, 0, 0, 0, 0, 0);
        check("lu_reader_stage1", 32'(bus.fwd_a), 1);

        // r0 writes and loads are never tracked as hazards
        apply(1, 1, 0, 0, 0, 0, 0, 1, 1, 0);
        apply(1, 1, 1, 0, 1, 0, 0, 1, 0, 0);
        check("r0_stall", 32'(bus.stall), 0);
        check("r0_fwd_a", 32'(bus.fwd_a), 0);
        check("r0_fwd_b", 32'(bus.fwd_b), 0);
        apply(1, 1, 1, 0, 1, 0, 0, 0, 0, 0);
        check("r0_fwd_a2", 32'(bus.fwd_a), 0);

        // lw r7 in stage 1, reader of r7 in decode, branch taken the same cycle
        apply(1, 1, 0, 0, 0, 0, 7, 1, 1, 0);
        apply(1, 1, 1, 7, 0, 0, 0, 0, 0, 1);
        check("br_flush", 32'(bus.flush), 1);
        check("br_stall", 32'(bus.stall), 0);
        apply(1, 1, 1, 7, 0, 0, 0, 0, 0, 0);
        check("br_killed_fwd", 32'(bus.fwd_a), 0);
        check("br_killed_stall", 32'(bus.stall), 0);
        check("br_flush_count", 32'(bus.flush_count), 1);

        // r4 in stages 1 and 3, r9 in stage 2
        apply(1, 1, 0, 0, 0, 0, 4, 1, 0, 0);
        apply(1, 1, 0, 0, 0, 0, 9, 1, 0, 0);
        apply(1, 1, 0, 0, 0, 0, 4, 1, 0, 0);
        apply(1, 1, 1, 4, 1, 9, 0, 0, 0, 0);
        check("young_fwd_a", 32'(bus.fwd_a), 1);
        check("young_fwd_b", 32'(bus.fwd_b), 2);
        apply(1, 1, 1, 4, 1, 9, 0, 0, 0, 0);
        check("young_fwd_a_next", 32'(bus.fwd_a), 2);
        check("young_fwd_b_next", 32'(bus.fwd_b), 3);

        // Reset in the middle of a load-use stall
        apply(1, 1, 0, 0, 0, 0, 8, 1, 1, 0);
        apply(0, 1, 1, 8, 0, 0, 0, 0, 0, 0);
        check("mid_rst_stall", 32'(bus.stall), 1);
        check("mid_rst_sc_before", 32'(bus.stall_count), 1);
        apply(1, 1, 1, 8, 0, 0, 0, 0, 0, 0);
        check("mid_rst_after_stall", 32'(bus.stall), 0);
        check("mid_rst_after_fwd", 32'(bus.fwd_a), 0);
        check("mid_rst_after_sc", 32'(bus.stall_count), 0);
        check("mid_rst_after_fc", 32'(bus.flush_count), 0);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("post_rst_flush", 32'(bus.flush), 1);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Deep pipeline: 15 stalls per 16-cycle round, 4370 rounds = 65550 stalls
        for (int r = 0; r < 4370; r++) begin
            apply2(1, 1, 5, 5, 1, 1);
            if (r == 0) begin
                check("deep_first_stall", 32'(bus2.stall), 0);
                check("deep_first_fwd", 32'(bus2.fwd_a), 0);
            end else if (r == 1) begin
                check("deep_wb_fwd", 32'(bus2.fwd_a), 16);
                check("deep_wb_stall", 32'(bus2.stall), 0);
                check("deep_sc_round1", 32'(bus2.stall_count), 15);
            end else if (r == 4369) begin
                check("deep_sc_at_max", 32'(bus2.stall_count), 32'hFFFF);
            end
            for (int j = 1; j < 16; j++) begin
                apply2(1, 1, 5, 6, 1, 0);
                if (r == 0) check("deep_stall_run", 32'(bus2.stall), 1);
            end
        end
        apply2(0, 0, 0, 0, 0, 0);
        check("deep_sc_saturated", 32'(bus2.stall_count), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
